// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-command signals shared by the
// unified-memory arbiter. The arbiter uses the slave view. Requesters and the
// memory model use the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    // Instruction-fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic [DATA_W-1:0] if_rdata;
    logic              if_rvalid;
    logic              if_flush;

    // Load/store requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic [DATA_W-1:0] d_rdata;
    logic              d_rvalid;

    // Memory command and return data
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;

    // Status
    logic              fetch_stall;

    modport slave (
        input  if_req, if_addr, if_flush,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rd_data,
        output if_gnt, if_rdata, if_rvalid,
        output d_gnt, d_rdata, d_rvalid,
        output mem_addr, mem_wr_en, mem_wr_data,
        output fetch_stall
    );

    modport master (
        output if_req, if_addr, if_flush,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rd_data,
        input  if_gnt, if_rdata, if_rvalid,
        input  d_gnt, d_rdata, d_rvalid,
        input  mem_addr, mem_wr_en, mem_wr_data,
        input  fetch_stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port unified-memory arbiter between instruction fetch and load/store.
//
// Handshake: a requester holds req and its address/data stable until gnt is
// high in the same cycle. gnt is combinational, and the transfer happens at
// the clock edge that ends the granted cycle. Nothing is buffered, so a denied
// request simply retries. Read data returns on rdata together with a one-cycle
// rvalid pulse. For a read granted in cycle t, that pulse is visible in cycle
// t+MEM_LAT+1. Stores never produce an rvalid.
//
// Data normally wins. A saturating starve counter counts consecutive denied
// fetch cycles. When it reaches STARVE_LIMIT, fetch wins the next contended
// cycle. A MEM_LAT-deep tag pipeline {valid, owner} follows each read through
// the memory so its data can be routed back. A branch redirect (if_flush)
// invalidates every fetch-owned tag, including one granted in the flush cycle.
module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_port_arbiter_if.slave     bus
);
    localparam int               CNT_W = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    // Tag bit positions: owner = 1 means fetch, 0 means data.
    localparam int               TAG_V = 1;
    localparam int               TAG_O = 0;

    logic [CNT_W-1:0]          starve_cnt_q, starve_cnt_d;
    logic [MEM_LAT-1:0][1:0]   tag_q, tag_d;
    logic                      if_rvalid_q, if_rvalid_d;
    logic                      d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]         if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]         d_rdata_q, d_rdata_d;

    logic                      if_req_v;
    logic                      d_req_v;
    logic                      force_if;
    logic                      if_win;
    logic                      d_win;
    logic                      rd_grant;
    logic [1:0]                tag_out;
    logic                      resp_valid;

    // Arbitration: data has priority unless fetch has starved to the limit.
    // Requests are masked while in reset so no grant or write can leak out.
    always_comb begin
        if_req_v = bus.if_req & rst_n;
        d_req_v  = bus.d_req & rst_n;
        force_if = (starve_cnt_q == LIMIT);
        if_win   = if_req_v & (~d_req_v | force_if);
        d_win    = d_req_v & ~if_win;
        rd_grant = if_win | (d_win & ~bus.d_we);
    end

    assign bus.if_gnt      = if_win;
    assign bus.d_gnt       = d_win;
    assign bus.fetch_stall = if_req_v & ~if_win;
    assign bus.mem_addr    = if_win ? bus.if_addr : (d_win ? bus.d_addr : '0);
    assign bus.mem_wr_en   = d_win & bus.d_we;
    assign bus.mem_wr_data = rst_n ? bus.d_wdata : '0;

    // Starve counter: count denied fetch cycles, saturating, clear otherwise.
    always_comb begin
        starve_cnt_d = '0;
        if (if_req_v & ~if_win) begin
            starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 1'b1;
        end
    end

    // Tag pipeline: record each granted read and drop fetch tags on a flush.
    always_comb begin
        tag_d        = '0;
        tag_d[0]     = {rd_grant & ~(if_win & bus.if_flush), if_win};
        for (int i = 1; i < MEM_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
            if (bus.if_flush & tag_q[i-1][TAG_O]) begin
                tag_d[i][TAG_V] = 1'b0;
            end
        end
    end

    // Response routing: the oldest tag selects which requester gets mem_rd_data.
    always_comb begin
        tag_out     = tag_q[MEM_LAT-1];
        resp_valid  = tag_out[TAG_V] & ~(bus.if_flush & tag_out[TAG_O]);
        if_rvalid_d = resp_valid & tag_out[TAG_O];
        d_rvalid_d  = resp_valid & ~tag_out[TAG_O];
        if_rdata_d  = if_rvalid_d ? bus.mem_rd_data : if_rdata_q;
        d_rdata_d   = d_rvalid_d ? bus.mem_rd_data : d_rdata_q;
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            tag_q        <= '0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            tag_q        <= tag_d;
            if_rvalid_q  <= if_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a behavioural synchronous memory.
// Inputs change 1 ns after the rising edge. Outputs are sampled on the falling edge.
module tb_mem_port_arbiter;
    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 16;
    localparam int MEM_LAT      = 1;
    localparam int STARVE_LIMIT = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .MEM_LAT     (MEM_LAT),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ---------------- memory model ----------------
    // Unwritten words read back as 0xA000 + address.
    logic [DATA_W-1:0] mem_data    [256];
    logic              mem_written [256];
    logic [DATA_W-1:0] rd_pipe     [MEM_LAT];
    logic [7:0]        mem_a;
    assign mem_a = bus.mem_addr[7:0];

    // Synchronous write plus read pipeline of MEM_LAT stages.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem_written[i] <= 1'b0;
        end else if (bus.mem_wr_en) begin
            mem_data[mem_a]    <= bus.mem_wr_data;
            mem_written[mem_a] <= 1'b1;
        end
        rd_pipe[0] <= (rst_n && mem_written[mem_a]) ? mem_data[mem_a]
                                                    : DATA_W'(16'hA000 + 16'(mem_a));
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_rd_data = rd_pipe[MEM_LAT-1];

    // ---------------- scoreboard ----------------
    int                n_checks = 0;
    int                n_errors = 0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.if_flush = 1'b0;
        bus.d_req    = 1'b0;
        bus.d_we     = 1'b0;
        bus.d_addr   = '0;
        bus.d_wdata  = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a, input logic flush);
        bus.if_req   = 1'b1;
        bus.if_addr  = a;
        bus.if_flush = flush;
    endtask

    task automatic data(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = a;
        bus.d_wdata = wd;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        // Reset with requests active: everything must be masked.
        fetch(16'h1234, 1'b0);
        data(1'b1, 16'h0055, 16'h0077);
        @(negedge clk);
        check("rst_if_gnt",      bus.if_gnt,      0);
        check("rst_d_gnt",       bus.d_gnt,       0);
        check("rst_mem_wr_en",   bus.mem_wr_en,   0);
        check("rst_fetch_stall", bus.fetch_stall, 0);
        check("rst_mem_addr",    bus.mem_addr,    0);
        check("rst_mem_wr_data", bus.mem_wr_data, 0);
        check("rst_if_rvalid",   bus.if_rvalid,   0);
        check("rst_d_rvalid",    bus.d_rvalid,    0);
        check("rst_if_rdata",    bus.if_rdata,    0);
        check("rst_d_rdata",     bus.d_rdata,     0);
        next_cycle();
        idle_inputs();
        next_cycle();
        rst_n = 1'b1;

        // Idle for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_gnt",    {bus.if_gnt, bus.d_gnt}, 0);
            check("idle_wr_en",  bus.mem_wr_en, 0);
            check("idle_rvalid", {bus.if_rvalid, bus.d_rvalid}, 0);
            check("idle_stall",  bus.fetch_stall, 0);
            next_cycle();
        end

        // Back-to-back fetches from addresses 0, 1 and 2.
        for (int i = 0; i < 6; i++) begin
            bus.if_req  = (i < 3);
            bus.if_addr = ADDR_W'(i);
            @(negedge clk);
            if (i < 3) begin
                check("t1_if_gnt",   bus.if_gnt,   1);
                check("t1_mem_addr", bus.mem_addr, 32'(i));
                exp_q.push_back(DATA_W'(16'hA000 + 16'(i)));
            end
            if (i >= 2 && i < 5) begin
                check("t1_if_rvalid", bus.if_rvalid, 1);
                check("t1_if_rdata",  bus.if_rdata,  exp_q.pop_front());
            end else begin
                check("t1_if_rvalid", bus.if_rvalid, 0);
            end
            next_cycle();
        end
        idle_inputs();

        // Store 0xBEEF to 0x40, then load it back on the next cycle.
        data(1'b1, 16'h0040, 16'hBEEF);
        @(negedge clk);
        check("t2_st_gnt",     bus.d_gnt,       1);
        check("t2_st_wr_en",   bus.mem_wr_en,   1);
        check("t2_st_addr",    bus.mem_addr,    32'h40);
        check("t2_st_wdata",   bus.mem_wr_data, 32'hBEEF);
        next_cycle();
        data(1'b0, 16'h0040, 16'h0000);
        @(negedge clk);
        check("t2_ld_gnt",     bus.d_gnt,     1);
        check("t2_ld_wr_en",   bus.mem_wr_en, 0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("t2_st_norv",    bus.d_rvalid,  0);
        next_cycle();
        @(negedge clk);
        check("t2_ld_rvalid",  bus.d_rvalid,  1);
        check("t2_ld_rdata",   bus.d_rdata,   32'hBEEF);
        next_cycle();
        @(negedge clk);
        check("t2_rv_pulse",   bus.d_rvalid,  0);
        next_cycle();

        // Continuous contention: four data grants, then one forced fetch.
        fetch(16'h0008, 1'b0);
        data(1'b0, 16'h0030, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_if_gnt", bus.if_gnt,      (i % 5 == 4) ? 1 : 0);
            check("t3_d_gnt",  bus.d_gnt,       (i % 5 == 4) ? 0 : 1);
            check("t3_stall",  bus.fetch_stall, (i % 5 == 4) ? 0 : 1);
            next_cycle();
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) next_cycle();

        // Fetch at 0x10 cancelled by a flush the next cycle, while a data load is in flight.
        fetch(16'h0010, 1'b0);
        @(negedge clk);
        check("t4_if_gnt", bus.if_gnt, 1);
        next_cycle();
        idle_inputs();
        bus.if_flush = 1'b1;
        data(1'b0, 16'h0020, 16'h0000);
        @(negedge clk);
        check("t4_d_gnt", bus.d_gnt, 1);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("t4_no_if_rv", bus.if_rvalid, 0);
        next_cycle();
        @(negedge clk);
        check("t4_no_if_rv2", bus.if_rvalid, 0);
        check("t4_d_rvalid",  bus.d_rvalid,  1);
        check("t4_d_rdata",   bus.d_rdata,   32'hA020);
        next_cycle();
        // A fetch granted in the flush cycle is dropped; the next one returns.
        fetch(16'h0011, 1'b1);
        @(negedge clk);
        check("t4_flush_gnt", bus.if_gnt, 1);
        next_cycle();
        fetch(16'h0012, 1'b0);
        @(negedge clk);
        check("t4_new_gnt", bus.if_gnt, 1);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("t4_same_cyc_rv", bus.if_rvalid, 0);
        next_cycle();
        @(negedge clk);
        check("t4_new_rvalid", bus.if_rvalid, 1);
        check("t4_new_rdata",  bus.if_rdata,  32'hA012);
        next_cycle();

        // Reset mid-stream with reads in flight.
        fetch(16'h0003, 1'b0);
        data(1'b0, 16'h0005, 16'h0000);
        @(negedge clk);
        check("t5_d_gnt", bus.d_gnt, 1);
        next_cycle();
        bus.d_req = 1'b0;
        @(negedge clk);
        check("t5_if_gnt", bus.if_gnt, 1);
        next_cycle();
        data(1'b1, 16'h0007, 16'h1111);
        #1;
        check("t5_pre_d_rv",  bus.d_rvalid,  1);
        check("t5_pre_wr_en", bus.mem_wr_en, 1);
        rst_n = 1'b0;
        #1;
        check("t5_if_gnt0",   bus.if_gnt,      0);
        check("t5_d_gnt0",    bus.d_gnt,       0);
        check("t5_wr_en0",    bus.mem_wr_en,   0);
        check("t5_d_rv0",     bus.d_rvalid,    0);
        check("t5_if_rv0",    bus.if_rvalid,   0);
        check("t5_stall0",    bus.fetch_stall, 0);
        idle_inputs();
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_no_stale", {bus.if_rvalid, bus.d_rvalid}, 0);
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory (mem_interface) between the instruction-fetch stage and the load/store stage.
- Arbitrates one access per cycle and drives the memory command.
- Tracks which requester owns each in-flight read and routes read data back with a valid pulse.
- Cancels in-flight fetch responses on a branch redirect.
- Provides a starvation guard so fetch always makes forward progress under continuous data traffic.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MEM_LAT, 1, read latency of the memory in cycles (1..4).
- STARVE_LIMIT, 4, consecutive cycles fetch may be denied before it is forced to win (1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch requests a read this cycle
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rdata  out  DATA_W  fetch read data
- if_rvalid  out  1  if_rdata valid (one-cycle pulse)
- if_flush  in  1  branch redirect; discard all outstanding fetch responses
- d_req  in  1  load/store requests an access this cycle
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rdata  out  DATA_W  load data
- d_rvalid  out  1  d_rdata valid (one-cycle pulse; never asserted for stores)
- mem_addr  out  ADDR_W  memory address
- mem_wr_en  out  1  memory write enable
- mem_wr_data  out  DATA_W  memory write data
- mem_rd_data  in  DATA_W  memory read data, valid MEM_LAT cycles after the address
- fetch_stall  out  1  if_req is pending and was not granted this cycle

Behaviour:
- Reset (asynchronous, rst_n low), all registered state cleared:
  - starve counter = 0
  - tag pipeline = all empty
  - if_rvalid = 0, d_rvalid = 0
  - if_rdata and d_rdata = 0
- While rst_n is low:
  - if_gnt, d_gnt, mem_wr_en and fetch_stall are forced to 0.
  - mem_addr and mem_wr_data are 0.
- Arbitration, one grant per cycle, combinational from current inputs:
  - Only d_req: data wins.
  - Only if_req: fetch wins.
  - Both requesting: data wins, unless starve counter == STARVE_LIMIT, in which case fetch wins.
  - Neither requesting: no grant.
- Memory command:
  - mem_addr = address of the winner (0 if no grant).
  - mem_wr_en = d_gnt & d_we.
  - mem_wr_data = d_wdata.
- Starve counter, updated at the clock edge:
  - Increments, saturating at STARVE_LIMIT, when if_req & ~if_gnt.
  - Clears to 0 when if_gnt or when ~if_req.
- fetch_stall = if_req & ~if_gnt.
- Tag pipeline: MEM_LAT-deep shift register of 2-bit tags {valid, owner}.
  - Stage 0 loads valid = 1 for any granted read (if_gnt, or d_gnt & ~d_we); owner = 1 for fetch, 0 for data.
  - Stores and idle cycles load an empty tag.
- Response: when the tag leaving stage MEM_LAT-1 is valid, in that same cycle:
  - mem_rd_data is copied to if_rdata or d_rdata per owner.
  - The matching rvalid is pulsed for one cycle.
  - rvalid and rdata are registered outputs. The response appears exactly MEM_LAT+1 clock edges after the grant edge, i.e. MEM_LAT+1 cycles after grant at MEM_LAT = 1.
  - The non-selected rdata holds its previous value.
- Flush:
  - if_flush clears the valid bit of every fetch-owned tag in the pipeline at that edge.
  - A fetch granted in the same cycle as if_flush is also not recorded; the new-target fetch is granted the next cycle.
  - Data-owned tags are untouched.
  - if_rvalid is never asserted for a cancelled access.
- Simultaneous flush and grant: the flush applies to prior and same-cycle fetch tags only.
- Stores complete at the grant edge; a load granted on the next cycle to the same address returns the stored data.
- Requesters must hold req and addr stable until gnt; the arbiter performs no buffering of denied requests.

Test Plan:
1. Reset, then if_req = 1 with if_addr = 0x0000, 0x0001, 0x0002 on consecutive cycles, memory preloaded with 0xA000+addr -> if_gnt = 1 each cycle; if_rvalid pulses with 0xA000, 0xA001, 0xA002 on consecutive cycles starting 2 cycles after the first grant.
2. Store d_addr = 0x0040, d_wdata = 0xBEEF, then load 0x0040 next cycle -> mem_wr_en = 1 for one cycle, no d_rvalid for the store; d_rvalid with 0xBEEF two cycles after the load grant.
3. if_req and d_req (load) held high continuously, STARVE_LIMIT = 4 -> d_gnt for 4 cycles, if_gnt on the 5th, pattern repeats; fetch_stall = 1 exactly on the denied cycles.
4. Fetch granted at 0x0010, if_flush asserted on the following cycle -> no if_rvalid for 0x0010; a data load in flight at the same time still returns with d_rvalid.
5. Assert rst_n low mid-stream with reads in flight -> all gnt, rvalid and mem_wr_en drop to 0 immediately; after release, no stale rvalid pulse is produced.
6. Neither requester active for 10 cycles -> mem_wr_en = 0, no gnt, no rvalid, starve counter stays 0.
